// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 8;
    localparam int MAX_REQ    = 8;

    // Command as presented to the RAM on the registered command stage.
    typedef struct packed {
        logic                  we;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] data;
    } ram_cmd_t;

    // One-hot decode of a requester index; callers truncate to their width.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
        return MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr wins.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] gnt_id_o,
    output logic            any_o
);

    // Scan upward from ptr, wrapping modulo N; stop at the first set request.
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = ID_W'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_id_o   = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters.
// Accepted command is registered to the RAM; reads return two edges later.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        arb_en_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        ram_we_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic [DATA_W-1:0]           ram_data_o,
    input  logic [DATA_W-1:0]           ram_q_i
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_elig;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               any;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    ram_cmd_t           cmd_q, cmd_d;
    logic               s1_vld_q, s1_vld_d;
    logic               s1_rd_q, s1_rd_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    // Reset is folded in so req_ready reads zero while the block is held in reset.
    assign req_elig = req_valid_i & {NUM_REQ{arb_en_i & rst_n_i}};

    rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_i    (req_elig),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (any)
    );

    assign req_ready_o = gnt;

    // Accept stage: capture the granted command and advance the pointer past the winner.
    always_comb begin
        cmd_d    = cmd_q;
        cmd_d.we = 1'b0;
        s1_vld_d = 1'b0;
        s1_rd_d  = s1_rd_q;
        s1_id_d  = s1_id_q;
        ptr_d    = ptr_q;
        if (any) begin
            cmd_d.we   = req_we_i[gnt_id];
            cmd_d.addr = req_addr_i[int'(gnt_id)*ADDR_W +: ADDR_W];
            cmd_d.data = req_wdata_i[int'(gnt_id)*DATA_W +: DATA_W];
            s1_vld_d   = 1'b1;
            s1_rd_d    = !req_we_i[gnt_id];
            s1_id_d    = gnt_id;
            ptr_d      = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // RAM and response stages: track read ownership until ram_q is valid.
    always_comb begin
        s2_vld_d    = s1_vld_q & s1_rd_q;
        s2_id_d     = s1_id_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (s2_vld_q) begin
            rsp_valid_d = NUM_REQ'(onehot(3'(s2_id_q)));
            rsp_rdata_d = ram_q_i;
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q       <= '0;
            cmd_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s1_id_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cmd_q       <= cmd_d;
            s1_vld_q    <= s1_vld_d;
            s1_rd_q     <= s1_rd_d;
            s1_id_q     <= s1_id_d;
            s2_vld_q    <= s2_vld_d;
            s2_id_q     <= s2_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_we_o    = cmd_q.we;
    assign ram_addr_o  = cmd_q.addr;
    assign ram_data_o  = cmd_q.data;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: external RAM behavioural model plus a
// transaction-level reference (grant scan, memory image, response schedule).
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        arb_en = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_we = '0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  ram_q;

    ram_port_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .arb_en_i    (arb_en),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_data),
        .ram_q_i     (ram_q)
    );

    always #5 clk = ~clk;

    // External single-port RAM with a preload port used only during reset.
    logic [7:0] ram_mem [64];
    logic       pl_en = 1'b0;
    logic [5:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) ram_mem[pl_addr] <= pl_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    int         cyc;
    int         m_ptr;
    logic [7:0] mmem [64];
    logic       m_we;
    logic [5:0] m_addr;
    logic [7:0] m_data;
    logic [3:0] m_rv;
    logic [7:0] m_rd;
    logic [3:0] q_rv [int];
    logic [7:0] q_rd [int];

    // Expected and observed values for the most recent cycle
    logic [3:0] e_gnt, e_rv, o_ready, o_rv;
    logic [7:0] e_rd, e_data, o_rd, o_data;
    logic       e_we, o_we;
    logic [5:0] e_addr, o_addr;

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_rv = '0; m_rd = '0;
        q_rv.delete(); q_rd.delete();
    endtask

    // One clock: sample at negedge against the model, then let the edge happen.
    task automatic run_cycle();
        int g, idx;
        logic w;
        logic [5:0] a;
        logic [7:0] d;
        @(negedge clk);
        g = -1;
        if (rst_n && arb_en)
            for (int i = 0; i < 4; i++) begin
                idx = (m_ptr + i) % 4;
                if (g < 0 && ((req_valid >> idx) & 4'd1) != 4'd0) g = idx;
            end
        e_gnt  = (g < 0) ? 4'd0 : 4'(1 << g);
        e_we   = m_we;  e_addr = m_addr; e_data = m_data;
        e_rv   = m_rv;  e_rd   = m_rd;
        o_ready = req_ready; o_rv = rsp_valid; o_rd = rsp_rdata;
        o_we    = ram_we;    o_addr = ram_addr; o_data = ram_data;
        @(posedge clk);
        cyc++;
        m_rv = q_rv.exists(cyc) ? q_rv[cyc] : 4'd0;
        if (m_rv != 0) m_rd = q_rd[cyc];
        m_we = 1'b0;
        if (g >= 0) begin
            w = ((req_we >> g) & 4'd1) != 4'd0;
            a = req_addr[g*6 +: 6];
            d = req_wdata[g*8 +: 8];
            m_we = w; m_addr = a; m_data = d;
            m_ptr = (g + 1) % 4;
            if (w) mmem[a] = d;
            else begin
                q_rv[cyc+2] = 4'(1 << g);
                q_rd[cyc+2] = mmem[a];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        cyc = 0;
        model_reset();
        arb_en = 1'b1; req_valid = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        nchk++; if (req_ready !== 4'd0) begin nerr++; $display("FAIL reset_ready: got %h expected 0", req_ready); end
        nchk++; if (rsp_valid !== 4'd0) begin nerr++; $display("FAIL reset_rsp_valid: got %h expected 0", rsp_valid); end
        nchk++; if (rsp_rdata !== 8'd0) begin nerr++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        nchk++; if (ram_we !== 1'b0) begin nerr++; $display("FAIL reset_ram_we: got %h expected 0", ram_we); end
        nchk++; if (ram_addr !== 6'd0) begin nerr++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
        nchk++; if (ram_data !== 8'd0) begin nerr++; $display("FAIL reset_ram_data: got %h expected 0", ram_data); end
        for (int i = 0; i < 64; i++) begin
            v = (i == 5) ? 8'hA5 : 8'($urandom);
            pl_en = 1'b1; pl_addr = 6'(i); pl_data = v; mmem[i] = v;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        run_cycle();
        nchk++; if (o_ready !== 4'd0) begin nerr++; $display("FAIL reset_hold_ready: got %h expected 0", o_ready); end
        rst_n = 1'b1; req_valid = 4'd0;
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        req_valid = 4'hF; req_we = 4'd0;
        req_addr = {6'd3, 6'd2, 6'd1, 6'd0};
        for (int c = 0; c < 11; c++) begin
            if (c == 8) req_valid = 4'd0;
            run_cycle();
            exp = (c < 8) ? 4'(1 << (c % 4)) : 4'd0;
            nchk++; if (o_ready !== exp) begin nerr++; $display("FAIL fair_grant[%0d]: got %b expected %b", c, o_ready, exp); end
            if (c >= 3) begin
                exp = 4'(1 << ((c - 3) % 4));
                nchk++; if (o_rv !== exp) begin nerr++; $display("FAIL fair_rsp_valid[%0d]: got %b expected %b", c, o_rv, exp); end
                nchk++; if (o_rd !== mmem[6'((c - 3) % 4)]) begin nerr++; $display("FAIL fair_rdata[%0d]: got %h expected %h", c, o_rd, mmem[6'((c - 3) % 4)]); end
            end
        end
    endtask

    task automatic test_single_read();
        req_valid = 4'b0010; req_we = 4'd0; req_addr = {6'd0, 6'd0, 6'd5, 6'd0};
        run_cycle();
        nchk++; if (o_ready !== 4'b0010) begin nerr++; $display("FAIL sr_ready: got %b expected 0010", o_ready); end
        req_valid = 4'd0;
        run_cycle();
        nchk++; if (o_addr !== 6'd5 || o_we !== 1'b0) begin nerr++; $display("FAIL sr_ram_cmd: got we=%b addr=%0d expected we=0 addr=5", o_we, o_addr); end
        run_cycle();
        nchk++; if (o_rv !== 4'd0) begin nerr++; $display("FAIL sr_early_rsp: got %b expected 0000", o_rv); end
        run_cycle();
        nchk++; if (o_rv !== 4'b0010) begin nerr++; $display("FAIL sr_rsp_valid: got %b expected 0010", o_rv); end
        nchk++; if (o_rd !== 8'hA5) begin nerr++; $display("FAIL sr_rdata: got %h expected a5", o_rd); end
        run_cycle();
        nchk++; if (o_rv !== 4'd0) begin nerr++; $display("FAIL sr_pulse_width: got %b expected 0000", o_rv); end
    endtask

    task automatic test_write_read();
        req_valid = 4'b0001; req_we = 4'b0001; req_addr = 24'd63; req_wdata = 32'h3C;
        run_cycle();
        nchk++; if (o_ready !== 4'b0001) begin nerr++; $display("FAIL wr_ready_w: got %b expected 0001", o_ready); end
        req_we = 4'd0; req_wdata = 32'h0;
        run_cycle();
        nchk++; if (o_ready !== 4'b0001) begin nerr++; $display("FAIL wr_ready_r: got %b expected 0001", o_ready); end
        nchk++; if (o_we !== 1'b1 || o_addr !== 6'd63 || o_data !== 8'h3C) begin nerr++; $display("FAIL wr_ram_write: got we=%b addr=%0d data=%h expected 1/63/3c", o_we, o_addr, o_data); end
        req_valid = 4'd0;
        run_cycle();
        nchk++; if (o_we !== 1'b0 || o_addr !== 6'd63) begin nerr++; $display("FAIL wr_ram_read: got we=%b addr=%0d expected 0/63", o_we, o_addr); end
        run_cycle();
        nchk++; if (o_rv !== 4'd0) begin nerr++; $display("FAIL wr_no_write_rsp: got %b expected 0000", o_rv); end
        run_cycle();
        nchk++; if (o_rv !== 4'b0001 || o_rd !== 8'h3C) begin nerr++; $display("FAIL wr_readback: got v=%b d=%h expected 0001/3c", o_rv, o_rd); end
    endtask

    task automatic test_gating();
        req_valid = 4'b0100; req_we = 4'd0; req_addr = {6'd10, 6'd9, 6'd0, 6'd0};
        run_cycle();
        nchk++; if (o_ready !== 4'b0100) begin nerr++; $display("FAIL gate_accept: got %b expected 0100", o_ready); end
        arb_en = 1'b0; req_valid = 4'hF;
        for (int c = 1; c <= 4; c++) begin
            run_cycle();
            nchk++; if (o_ready !== 4'd0) begin nerr++; $display("FAIL gate_ready[%0d]: got %b expected 0000", c, o_ready); end
            if (c == 3) begin
                nchk++; if (o_rv !== 4'b0100 || o_rd !== mmem[9]) begin nerr++; $display("FAIL gate_drain: got v=%b d=%h expected 0100/%h", o_rv, o_rd, mmem[9]); end
            end
        end
        arb_en = 1'b1;
        run_cycle();
        nchk++; if (o_ready !== 4'b1000) begin nerr++; $display("FAIL gate_ptr_kept: got %b expected 1000", o_ready); end
        req_valid = 4'd0;
        for (int c = 0; c < 3; c++) run_cycle();
        nchk++; if (o_rv !== 4'b1000 || o_rd !== mmem[10]) begin nerr++; $display("FAIL gate_last_rsp: got v=%b d=%h expected 1000/%h", o_rv, o_rd, mmem[10]); end
    endtask

    task automatic test_idle();
        req_valid = 4'd0;
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            nchk++; if (o_we !== 1'b0 || o_rv !== 4'd0) begin nerr++; $display("FAIL idle_quiet[%0d]: got we=%b rv=%b expected 0/0000", c, o_we, o_rv); end
            nchk++; if (o_addr !== 6'd10) begin nerr++; $display("FAIL idle_addr_hold[%0d]: got %0d expected 10", c, o_addr); end
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0010; req_we = 4'd0; req_addr = {6'd0, 6'd0, 6'd7, 6'd0};
        run_cycle();
        nchk++; if (o_ready !== 4'b0010) begin nerr++; $display("FAIL rm_accept: got %b expected 0010", o_ready); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        nchk++; if (req_ready !== 4'd0 || rsp_valid !== 4'd0 || rsp_rdata !== 8'd0) begin nerr++; $display("FAIL rm_outputs_a: got rdy=%b rv=%b rd=%h expected zeros", req_ready, rsp_valid, rsp_rdata); end
        nchk++; if (ram_we !== 1'b0 || ram_addr !== 6'd0 || ram_data !== 8'd0) begin nerr++; $display("FAIL rm_outputs_b: got we=%b addr=%0d data=%h expected zeros", ram_we, ram_addr, ram_data); end
        run_cycle();
        run_cycle();
        rst_n = 1'b1; req_valid = 4'd0;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            nchk++; if (o_rv !== 4'd0) begin nerr++; $display("FAIL rm_no_rsp[%0d]: got %b expected 0000", c, o_rv); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            arb_en    = ($urandom_range(0, 9) != 0);
            req_valid = 4'($urandom);
            req_we    = 4'($urandom);
            req_addr  = 24'($urandom) & 24'h1C71C7;
            req_wdata = $urandom;
            run_cycle();
            nchk++; if (o_ready !== e_gnt) begin nerr++; $display("FAIL rnd_grant[%0d]: got %b expected %b", c, o_ready, e_gnt); end
            nchk++; if (o_rv !== e_rv) begin nerr++; $display("FAIL rnd_rsp_valid[%0d]: got %b expected %b", c, o_rv, e_rv); end
            nchk++; if (o_rd !== e_rd) begin nerr++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, o_rd, e_rd); end
            nchk++; if (o_we !== e_we || o_addr !== e_addr || o_data !== e_data) begin nerr++; $display("FAIL rnd_ram_cmd[%0d]: got %b/%0d/%h expected %b/%0d/%h", c, o_we, o_addr, o_data, e_we, e_addr, e_data); end
        end
        req_valid = 4'd0;
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            nchk++; if (o_rv !== e_rv || o_rd !== e_rd) begin nerr++; $display("FAIL rnd_drain[%0d]: got %b/%h expected %b/%h", c, o_rv, o_rd, e_rv, e_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_write_read();
        test_gating();
        test_idle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one 64x8 single-port RAM among NUM_REQ requesters.
- Accepts one read or write command per cycle using a valid/ready handshake and issues it to the RAM through a registered command stage.
- Routes read data back to the requester that issued the read.
- Sits between client blocks and the RAM instance; the RAM itself is external to this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 6, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- arb_en  in  1  arbitration enable; 0 = issue no new grants.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_we  in  NUM_REQ  per-requester command type; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe, registered.
- rsp_rdata  out  DATA_W  read data, shared by all requesters; qualified by rsp_valid.
- ram_we  out  1  RAM write enable, registered.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_data  out  DATA_W  RAM write data, registered.
- ram_q  in  DATA_W  RAM read data; valid in the cycle after the RAM samples a read address.

Behaviour:
- Reset (async on rst_n low):
  - req_ready, rsp_valid, ram_we, ram_addr, ram_data, rsp_rdata = 0.
  - Round-robin pointer ptr = 0.
  - Pipeline valid bits = 0.
- Arbitration (combinational):
  - If arb_en = 1, scan req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit wins, and only that bit of req_ready is asserted.
  - If no request is valid or arb_en = 0, req_ready = 0.
  - req_ready does not depend on the previous grant; the block accepts one command every cycle.
- Accept: a transfer occurs at edge k when req_valid[i] & req_ready[i]. At that edge:
  - ram_we <= req_we[i]; ram_addr <= addr[i]; ram_data <= wdata[i].
  - s1_vld <= 1; s1_rd <= !req_we[i]; s1_id <= i.
  - ptr <= (i+1) mod NUM_REQ.
- Idle cycle (no transfer):
  - ram_we <= 0; s1_vld <= 0.
  - ram_addr and ram_data hold their previous values.
  - ptr is unchanged.
- RAM stage:
  - The RAM samples the command at edge k+1.
  - For a read, ram_q is valid during cycle k+1 → k+2.
  - Stage 2 registers at edge k+1: s2_vld <= s1_vld & s1_rd; s2_id <= s1_id.
- Response:
  - At edge k+2, if s2_vld: rsp_valid <= onehot(s2_id) and rsp_rdata <= ram_q.
  - Otherwise rsp_valid <= 0 and rsp_rdata holds.
  - Read latency is exactly 2 cycles from acceptance to the rsp_valid pulse, which lasts 1 cycle.
  - Writes produce no response.
- Ordering:
  - Commands reach the RAM in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data.
  - Back-to-back reads return one per cycle, in order.
- arb_en = 0: no new grants are issued; commands already in flight complete normally, so the pipeline drains.
- Single requester: a requester holding req_valid high is granted every cycle (ptr wraps back to it).
- Starvation bound: a continuously valid requester waits at most NUM_REQ-1 cycles for a grant.
- Reset mid-operation: all in-flight commands are discarded; no rsp_valid is produced after reset deasserts for commands accepted before reset.
- No backpressure on responses; requesters must accept a rsp_valid pulse in the cycle it appears.

Decomposition:
- Package ram_arb_pkg:
  - Constants RAM_ADDR_W = 6 and RAM_DATA_W = 8.
  - Typedef ram_cmd_t {we, addr, data}.
  - Function onehot(id).
- Sub-module rr_pick: parameterised combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot gnt, gnt_id, any.
  - Instantiated once.
- All pipeline stages stay in the top module.

Test Plan:
- Single read: after reset, requester 1 reads addr 5, which was preloaded with 0xA5 → req_ready = 4'b0010 at accept, ram_addr = 5 and ram_we = 0 one cycle later, rsp_valid = 4'b0010 with rsp_rdata = 0xA5 exactly 2 cycles after accept.
- Write then read: requester 0 writes 0x3C to addr 63, then reads addr 63 in the next cycle → ram_we pulse with ram_addr = 63 and ram_data = 0x3C, followed by rsp_valid[0] with rsp_rdata = 0x3C.
- Fairness: all 4 requesters hold reads of addr i for 8 cycles → grant sequence 0,1,2,3,0,1,2,3; rsp_valid follows the same sequence 2 cycles later, and each requester receives rdata = its preloaded value.
- Gating: raise arb_en = 0 the cycle after a read is accepted → req_ready = 0 from then on, the in-flight read still completes, and ptr is unchanged when arb_en returns to 1.
- Reset mid-flight: assert rst_n = 0 one cycle after a read is accepted → all outputs 0 immediately, and no rsp_valid appears after release.
- Idle: no req_valid for 10 cycles → ram_we = 0, rsp_valid = 0, ram_addr stable.
